// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, addresses instruction memory and fills the IF/ID register.
// Two-state FSM (RUN/HALT); HALT is entered on ECALL/EBREAK and is left only by reset.
module instr_fetch #(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic              if_valid,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_instr,
  output logic              halted
);

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic {RUN, HALT} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        valid_q;
  logic [31:0] if_pc_q;
  logic [31:0] instr_q;
  logic        halted_q;

  logic        halt_instr;
  logic [31:0] pc_plus4;
  logic        unused_redirect_bits;

  assign halt_instr           = (imem_data == ECALL) || (imem_data == EBREAK);
  assign pc_plus4             = pc_q + 32'd4;
  assign unused_redirect_bits = ^redirect_pc[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      if_pc_q  <= 32'h0;
      instr_q  <= NOP;
      halted_q <= 1'b0;
    end else begin
      // halted lags the state by one edge
      halted_q <= (state_q == HALT);
      case (state_q)
        RUN: begin
          if (redirect_valid) begin
            pc_q    <= {redirect_pc[31:2], 2'b00};
            valid_q <= 1'b0;
            instr_q <= NOP;
            if_pc_q <= 32'h0;
          end else if (!stall) begin
            instr_q <= imem_data;
            if_pc_q <= pc_q;
            valid_q <= 1'b1;
            if (halt_instr) begin
              state_q <= HALT;
            end else begin
              pc_q <= pc_plus4;
            end
          end
        end
        HALT: begin
          // a stalled ECALL/EBREAK stays in IF/ID until the stall clears
          if (!stall) begin
            valid_q <= 1'b0;
            instr_q <= NOP;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign imem_addr = pc_q[ADDR_W+1:2];
  assign if_valid  = valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = instr_q;
  assign halted    = halted_q;

endmodule
